// File: rtl/keypad_emulator.sv
// Keypad emulator: presses one key for PRESS_CYCLES, then forces a RELEASE_CYCLES gap,
// answering the scanner's column strobe combinationally with the pressed key's row.
module keypad_emulator #(
    parameter int unsigned PRESS_CYCLES   = 16,
    parameter int unsigned RELEASE_CYCLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [1:0] col_selector,
    output logic [1:0] row_result,
    output logic       valid_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        RELEASE
    } state_t;

    localparam logic [7:0] PRESS_LOAD   = 8'(PRESS_CYCLES - 1);
    localparam logic [7:0] RELEASE_LOAD = 8'(RELEASE_CYCLES - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] kreg, kreg_n;
    logic       done_n;
    logic [7:0] count_n;
    logic [1:0] key_col, key_row;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            kreg        <= '0;
            done        <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            kreg        <= kreg_n;
            done        <= done_n;
            press_count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        kreg_n  = kreg;
        done_n  = 1'b0;
        count_n = press_count;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    kreg_n  = key_in;
                    cnt_n   = PRESS_LOAD;
                    state_n = PRESS;
                end
            end
            PRESS: begin
                if (cnt == 8'd0) begin
                    cnt_n   = RELEASE_LOAD;
                    state_n = RELEASE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            RELEASE: begin
                if (cnt == 8'd0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    count_n = press_count + 8'd1;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Physical 4x4 layout: columns 1-2-3-A, rows counted from the top row (3) down to 0.
    always_comb begin
        key_col = 2'd0;
        key_row = 2'd0;
        case (kreg)
            4'h1: begin key_col = 2'd0; key_row = 2'd3; end
            4'h4: begin key_col = 2'd0; key_row = 2'd2; end
            4'h7: begin key_col = 2'd0; key_row = 2'd1; end
            4'hF: begin key_col = 2'd0; key_row = 2'd0; end
            4'h2: begin key_col = 2'd1; key_row = 2'd3; end
            4'h5: begin key_col = 2'd1; key_row = 2'd2; end
            4'h8: begin key_col = 2'd1; key_row = 2'd1; end
            4'h0: begin key_col = 2'd1; key_row = 2'd0; end
            4'h3: begin key_col = 2'd2; key_row = 2'd3; end
            4'h6: begin key_col = 2'd2; key_row = 2'd2; end
            4'h9: begin key_col = 2'd2; key_row = 2'd1; end
            4'hE: begin key_col = 2'd2; key_row = 2'd0; end
            4'hA: begin key_col = 2'd3; key_row = 2'd3; end
            4'hB: begin key_col = 2'd3; key_row = 2'd2; end
            4'hC: begin key_col = 2'd3; key_row = 2'd1; end
            4'hD: begin key_col = 2'd3; key_row = 2'd0; end
            default: begin key_col = 2'd0; key_row = 2'd0; end
        endcase
    end

    assign key_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign valid_out  = (state == PRESS) && (col_selector == key_col);
    assign row_result = valid_out ? key_row : 2'b00;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: key-map table with a scoreboard of expected
// (column,row) per press, plus timing, busy-ignore, reset-abort and count-wrap sequences.
module tb_keypad_emulator;

    typedef struct {
        logic [3:0] key;
        logic [1:0] col;
        logic [1:0] row;
    } key_vec_t;

    typedef struct {
        logic [1:0] col;
        logic [1:0] row;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic [1:0] col_selector;
    logic [1:0] row_result;
    logic       valid_out;
    logic       busy;
    logic       done;
    logic [7:0] press_count;

    logic [3:0] key_in1;
    logic       key_valid1;
    logic       key_ready1;
    logic [1:0] col_selector1;
    logic [1:0] row_result1;
    logic       valid_out1;
    logic       busy1;
    logic       done1;
    logic [7:0] press_count1;

    int         checks;
    int         failures;
    exp_t       exp_q[$];
    logic [7:0] cnt_q[$];
    key_vec_t   vecs[16];

    keypad_emulator #(.PRESS_CYCLES(16), .RELEASE_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .col_selector(col_selector), .row_result(row_result),
        .valid_out(valid_out), .busy(busy), .done(done), .press_count(press_count)
    );

    keypad_emulator #(.PRESS_CYCLES(1), .RELEASE_CYCLES(1)) dut_fast (
        .clock(clock), .reset(reset), .key_in(key_in1), .key_valid(key_valid1),
        .key_ready(key_ready1), .col_selector(col_selector1), .row_result(row_result1),
        .valid_out(valid_out1), .busy(busy1), .done(done1), .press_count(press_count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int unsigned n;
        n = 0;
        while (!key_ready && n < 60) begin
            tick();
            n++;
        end
        check("wait_ready", key_ready, 1);
    endtask

    // Sweep columns while busy; record which columns lit and the row seen, then score at done.
    task automatic sweep_and_score(input string name);
        int unsigned n;
        logic [3:0] mask;
        logic [1:0] seen_row;
        exp_t e;
        mask = '0;
        seen_row = '0;
        n = 0;
        while (busy && n < 40) begin
            col_selector = 2'(n % 4);
            #1;
            if (valid_out) begin
                mask[col_selector] = 1'b1;
                seen_row = row_result;
            end
            tick();
            n++;
        end
        check({name, "_ends"}, busy, 0);
        check({name, "_done"}, done, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, "_colmask"}, mask, 32'(4'b0001 << e.col));
            check({name, "_row"}, seen_row, e.row);
        end else begin
            check({name, "_scoreboard_empty"}, 1, 0);
        end
    endtask

    task automatic run_key(input logic [3:0] key, input logic [1:0] col, input logic [1:0] row);
        wait_ready();
        key_in = key;
        key_valid = 1'b1;
        exp_q.push_back('{col, row});
        tick();
        key_valid = 1'b0;
        sweep_and_score($sformatf("key%0h", key));
    endtask

    initial begin
        logic       saw_done;
        int unsigned pushed, dones, last_done;
        logic       have_last;
        logic [7:0] exp_cnt;

        checks = 0;
        failures = 0;
        vecs = '{
            '{4'h1, 2'd0, 2'd3}, '{4'h4, 2'd0, 2'd2}, '{4'h7, 2'd0, 2'd1}, '{4'hF, 2'd0, 2'd0},
            '{4'h2, 2'd1, 2'd3}, '{4'h5, 2'd1, 2'd2}, '{4'h8, 2'd1, 2'd1}, '{4'h0, 2'd1, 2'd0},
            '{4'h3, 2'd2, 2'd3}, '{4'h6, 2'd2, 2'd2}, '{4'h9, 2'd2, 2'd1}, '{4'hE, 2'd2, 2'd0},
            '{4'hA, 2'd3, 2'd3}, '{4'hB, 2'd3, 2'd2}, '{4'hC, 2'd3, 2'd1}, '{4'hD, 2'd3, 2'd0}
        };

        reset = 1'b1;
        key_in = '0;
        key_valid = 1'b0;
        col_selector = '0;
        key_in1 = '0;
        key_valid1 = 1'b0;
        col_selector1 = '0;
        tick();
        tick();
        check("rst_ready", key_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", valid_out, 0);
        check("rst_row", row_result, 0);
        check("rst_done", done, 0);
        check("rst_count", press_count, 0);
        check("rst_count_fast", press_count1, 0);
        reset = 1'b0;
        tick();

        // Key 5 with defaults: cycle k is the k-th cycle after the accept edge.
        key_in = 4'h5;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int unsigned k = 1; k <= 27; k++) begin
            col_selector = 2'((k - 1) % 4);
            #1;
            check($sformatf("k5_valid_c%0d", k), valid_out, (k <= 16 && col_selector == 2'd1) ? 1 : 0);
            check($sformatf("k5_row_c%0d", k), row_result, (k <= 16 && col_selector == 2'd1) ? 2 : 0);
            check($sformatf("k5_busy_c%0d", k), busy, (k <= 24) ? 1 : 0);
            check($sformatf("k5_ready_c%0d", k), key_ready, (k >= 25) ? 1 : 0);
            check($sformatf("k5_done_c%0d", k), done, (k == 25) ? 1 : 0);
            check($sformatf("k5_count_c%0d", k), press_count, (k >= 25) ? 1 : 0);
            tick();
        end

        for (int i = 0; i < 16; i++) begin
            run_key(vecs[i].key, vecs[i].col, vecs[i].row);
        end
        check("count_after_table", press_count, 17);

        // F accepted, then D held valid throughout F's sequence must wait for key_ready.
        wait_ready();
        key_in = 4'hF;
        key_valid = 1'b1;
        exp_q.push_back('{2'd0, 2'd0});
        tick();
        key_in = 4'hD;
        check("fd_not_ready", key_ready, 0);
        sweep_and_score("fd_first");
        tick();
        key_valid = 1'b0;
        check("fd_second_busy", busy, 1);
        col_selector = 2'd3;
        #1;
        check("fd_d_valid", valid_out, 1);
        check("fd_d_row", row_result, 0);
        col_selector = 2'd0;
        #1;
        check("fd_d_col0", valid_out, 0);
        exp_q.push_back('{2'd3, 2'd0});
        tick();
        sweep_and_score("fd_second");
        check("count_after_fd", press_count, 19);

        // Reset in the fifth PRESS cycle of key 9 aborts silently.
        wait_ready();
        key_in = 4'h9;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        col_selector = 2'd2;
        #1;
        check("abort_pre_valid", valid_out, 1);
        check("abort_pre_row", row_result, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", key_ready, 1);
        check("abort_valid", valid_out, 0);
        check("abort_row", row_result, 0);
        check("abort_count", press_count, 0);
        saw_done = done;
        for (int i = 0; i < 30; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_count_later", press_count, 0);

        // Fast instance: 256 back-to-back sequences, count scored at each done pulse.
        pushed = 0;
        dones = 0;
        last_done = 0;
        have_last = 1'b0;
        key_valid1 = 1'b1;
        for (int unsigned c = 0; c < 780; c++) begin
            if (done1) begin
                dones++;
                if (cnt_q.size() > 0) begin
                    exp_cnt = cnt_q.pop_front();
                    check($sformatf("wrap_count_%0d", dones), press_count1, exp_cnt);
                end else begin
                    check("wrap_scoreboard_empty", 1, 0);
                end
                if (have_last) check($sformatf("wrap_period_%0d", dones), c - last_done, 3);
                last_done = c;
                have_last = 1'b1;
            end
            if (key_ready1 && key_valid1 && pushed < 256) begin
                pushed++;
                cnt_q.push_back(8'(pushed));
                key_in1 = key_in1 + 4'd1;
            end else if (pushed == 256 && !key_ready1) begin
                key_valid1 = 1'b0;
            end
            tick();
        end
        check("wrap_dones", dones, 256);
        check("wrap_final_count", press_count1, 0);
        check("wrap_queue_drained", cnt_q.size(), 0);
        check("wrap_idle", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter PRESS_CYCLES, default 16: clock cycles a key is held pressed; legal range 1..255.
REQ-002 Parameter RELEASE_CYCLES, default 8: clock cycles of forced release gap after each press; legal range 1..255.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 key_in  input  4  key code to press: 0-9 = digits, A-D = letters, E = '#', F = '*'.
REQ-006 key_valid  input  1  key_in valid; request to press.
REQ-007 key_ready  output  1  high when a new key can be accepted.
REQ-008 col_selector  input  2  column currently driven by the keypad scanner.
REQ-009 row_result  output  2  encoded row of the pressed key in the selected column.
REQ-010 valid_out  output  1  high when the selected column contains the pressed key.
REQ-011 busy  output  1  high in PRESS or RELEASE.
REQ-012 done  output  1  one-cycle pulse when a press/release sequence completes.
REQ-013 press_count  output  8  number of completed sequences, modulo 256.

Function
REQ-014 FSM states IDLE, PRESS, RELEASE; 8-bit down-counter cnt; 4-bit key register kreg.
REQ-015 key_ready SHALL equal (state == IDLE); busy SHALL equal (state != IDLE).
REQ-016 Accept: at a rising edge with key_valid && key_ready, kreg <= key_in, cnt <= PRESS_CYCLES-1, state <= PRESS.
REQ-017 key_valid while key_ready is low SHALL be ignored; key_in is not captured and not queued.
REQ-018 PRESS: cnt decrements each cycle; at cnt == 0, cnt <= RELEASE_CYCLES-1, state <= RELEASE; PRESS lasts exactly PRESS_CYCLES cycles.
REQ-019 RELEASE: cnt decrements each cycle; at cnt == 0, state <= IDLE, done <= 1, press_count <= press_count + 1; RELEASE lasts exactly RELEASE_CYCLES cycles.
REQ-020 done SHALL be registered, high only in the first IDLE cycle after RELEASE; low otherwise.
REQ-021 press_count SHALL wrap 255 -> 0 with no flag.
REQ-022 Key map (column, row) for kreg: 1=(0,11) 4=(0,10) 7=(0,01) F=(0,00); 2=(1,11) 5=(1,10) 8=(1,01) 0=(1,00); 3=(2,11) 6=(2,10) 9=(2,01) E=(2,00); A=(3,11) B=(3,10) C=(3,01) D=(3,00).
REQ-023 valid_out SHALL be combinational: (state == PRESS) && (col_selector == column of kreg); zero-latency response to col_selector.
REQ-024 row_result SHALL equal row of kreg when valid_out is high, else 2'b00.
REQ-025 Outside PRESS, valid_out SHALL be 0 regardless of col_selector.
REQ-026 Accept in the same cycle IDLE is entered after done is permitted only on the following edge (key_ready rises with done); back-to-back sequences have no extra idle cycle beyond that one.
REQ-027 col_selector changes during PRESS SHALL be tracked every cycle; kreg SHALL NOT change until the next accept.

Reset
REQ-028 reset high at a rising edge: state <= IDLE, cnt <= 0, kreg <= 0, done <= 0, press_count <= 0; overrides any accept or count in that cycle.
REQ-029 During and after reset: key_ready = 1 (from the first cycle after the reset edge), busy = 0, valid_out = 0, row_result = 2'b00.
REQ-030 reset asserted mid-PRESS or mid-RELEASE SHALL abort the sequence with no done pulse and no press_count increment.

Verification
REQ-031 Defaults, key_in=5 accepted at edge T, col_selector rotating 0,1,2,3 -> valid_out=1 and row_result=2'b10 only when col_selector=1, during cycles T+1..T+16; 0 elsewhere.
REQ-032 Same run -> busy high T+1..T+24; done=1 and press_count=1 in cycle T+25 only; key_ready high again at T+25.
REQ-033 key_in=F, then key_in=D held with key_valid=1 during busy -> only F pressed (col 0, row 00); D accepted at first edge with key_ready=1, pressed at (3,00).
REQ-034 Reset asserted at PRESS cycle 5 of key 9 -> next cycle IDLE, valid_out=0, no done, press_count unchanged (0).
REQ-035 256 back-to-back sequences with PRESS_CYCLES=1, RELEASE_CYCLES=1 -> press_count wraps to 0, 256 done pulses, each sequence 3 cycles accept-to-accept.
REQ-036 All 16 codes pressed, col_selector swept 0..3 per press -> exactly one column asserts valid_out per key with row per REQ-022.
